// File: rtl/video_pattern_pkg.sv
// Shared types and constants for the AXI4-Stream video pattern generator.
// Pure declarations: no latency, no flow control.
package video_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_HRAMP = 3'd0,
        MODE_VRAMP = 3'd1,
        MODE_CHECK = 3'd2,
        MODE_CONST = 3'd3,
        MODE_NOISE = 3'd4
    } pattern_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } gen_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in right-shifting form: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/axis_video_pattern_gen_lfsr16.sv
// 16-bit Fibonacci LFSR; new state one cycle after en, reseed wins over en.
// No flow control: the caller gates en with its own handshake.
module lfsr16
    import video_pattern_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        reseed,
    output logic [15:0] state
);

    logic fb;

    assign fb = ^(state & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else if (reseed) begin
            state <= LFSR_SEED;
        end else if (en) begin
            state <= {fb, state[15:1]};
        end
    end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video source with selectable patterns and line/frame blanking; tvalid one cycle after start.
// Backpressure: beat outputs hold while tready=0; position and LFSR advance only on accepted beats.
module axis_video_pattern_gen
    import video_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 1024,
    parameter int H_BLANK    = 16,
    parameter int V_BLANK    = 64,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                           i_sys_clk,
    input  logic                           i_sys_aresetn,
    input  logic                           i_start,
    input  logic                           i_continuous,
    input  logic                           i_enable,
    input  logic [2:0]                     i_mode,
    input  logic [DATA_WIDTH-1:0]          i_const_value,
    output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tuser,
    output logic                           m_axis_tlast,
    output logic                           o_busy,
    output logic [15:0]                    o_frame_cnt
);

    localparam int XW      = $clog2(WIDTH);
    localparam int YW      = $clog2(HEIGHT);
    localparam int BMAX    = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BW      = (BMAX > 1) ? $clog2(BMAX) : 1;
    localparam int HB_LAST = (H_BLANK > 0) ? H_BLANK - 1 : 0;
    localparam int VB_LAST = (V_BLANK > 0) ? V_BLANK - 1 : 0;

    gen_state_t                    state, state_nxt;
    logic [XW-1:0]                 x;
    logic [YW-1:0]                 y;
    logic [BW-1:0]                 blank_cnt;
    logic [2:0]                    mode_q;
    logic [15:0]                   lfsr;
    logic                          launch;
    logic                          accept;
    logic                          line_end;
    logic                          frame_end;
    logic                          restart_ok;
    logic [31:0]                   x_ext;
    logic [31:0]                   y_ext;
    logic                          checker_on;
    logic [CHANNELS*DATA_WIDTH-1:0] pix;

    assign restart_ok = i_continuous & i_enable;
    assign accept     = (state == ST_ACTIVE) & m_axis_tready;
    assign line_end   = (x == XW'(WIDTH - 1));
    assign frame_end  = line_end & (y == YW'(HEIGHT - 1));

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // launch marks every frame start: it latches the mode and reseeds the LFSR.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start | restart_ok) begin
                    state_nxt = ST_ACTIVE;
                    launch    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (accept && line_end) begin
                    if (frame_end) begin
                        if (V_BLANK > 0) begin
                            state_nxt = ST_VBLANK;
                        end else if (restart_ok) begin
                            launch = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else if (H_BLANK > 0) begin
                        state_nxt = ST_HBLANK;
                    end
                end
            end
            ST_HBLANK: begin
                if (blank_cnt == BW'(HB_LAST)) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_VBLANK: begin
                if (blank_cnt == BW'(VB_LAST)) begin
                    if (restart_ok) begin
                        state_nxt = ST_ACTIVE;
                        launch    = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tvalid = (state == ST_ACTIVE);
        m_axis_tuser  = (state == ST_ACTIVE) && (x == '0) && (y == '0);
        m_axis_tlast  = (state == ST_ACTIVE) && line_end;
        o_busy        = (state != ST_IDLE);
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            x           <= '0;
            y           <= '0;
            blank_cnt   <= '0;
            mode_q      <= '0;
            o_frame_cnt <= '0;
        end else begin
            if (launch) begin
                mode_q <= i_mode;
            end
            // Counts cycles spent in a blanking state; cleared on every state change.
            if ((state_nxt == state) && ((state == ST_HBLANK) || (state == ST_VBLANK))) begin
                blank_cnt <= blank_cnt + 1'b1;
            end else begin
                blank_cnt <= '0;
            end
            if (accept) begin
                if (line_end) begin
                    x <= '0;
                    if (frame_end) begin
                        y           <= '0;
                        o_frame_cnt <= o_frame_cnt + 16'd1;
                    end else begin
                        y <= y + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    lfsr16 u_lfsr (
        .clk    (i_sys_clk),
        .rst_n  (i_sys_aresetn),
        .en     (accept),
        .reseed (launch),
        .state  (lfsr)
    );

    // Pixel is a pure function of registered position/mode/LFSR, so it holds during stalls.
    always_comb begin
        x_ext      = 32'(x);
        y_ext      = 32'(y);
        checker_on = x_ext[CHECK_LOG2] ^ y_ext[CHECK_LOG2];
        pix        = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (mode_q)
                MODE_HRAMP: pix[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(x_ext + 32'(c));
                MODE_VRAMP: pix[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(y_ext + 32'(c));
                MODE_CHECK: pix[c*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{checker_on}};
                MODE_CONST: pix[c*DATA_WIDTH +: DATA_WIDTH] = i_const_value;
                MODE_NOISE: pix[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(lfsr);
                default:    pix[c*DATA_WIDTH +: DATA_WIDTH] = '0;
            endcase
        end
        m_axis_tdata = (state == ST_ACTIVE) ? pix : '0;
    end

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Randomized self-checking bench for axis_video_pattern_gen on an 8x4 frame with short blanking.
module tb_axis_video_pattern_gen;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int HB = 2;
    localparam int VB = 3;
    localparam int CL = 1;
    localparam int NB = W * H;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_continuous = 1'b0;
    logic        i_enable = 1'b0;
    logic [2:0]  i_mode = 3'd0;
    logic [7:0]  i_const_value = 8'd0;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        tuser;
    logic        tlast;
    logic        busy;
    logic [15:0] fcnt;

    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    int   stall_viol = 0;
    int   stall_n = 0;
    bit   rand_rdy = 1'b0;
    int   start_cyc = 0;
    int   exp_frames = 0;
    pix_t beats[$];
    int   bcyc[$];
    bit   prev_stall = 1'b0;
    pix_t prev_beat;

    axis_video_pattern_gen #(
        .DATA_WIDTH (8),
        .CHANNELS   (3),
        .WIDTH      (W),
        .HEIGHT     (H),
        .H_BLANK    (HB),
        .V_BLANK    (VB),
        .CHECK_LOG2 (CL)
    ) dut (
        .i_sys_clk     (clk),
        .i_sys_aresetn (rst_n),
        .i_start       (i_start),
        .i_continuous  (i_continuous),
        .i_enable      (i_enable),
        .i_mode        (i_mode),
        .i_const_value (i_const_value),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tuser  (tuser),
        .m_axis_tlast  (tlast),
        .o_busy        (busy),
        .o_frame_cnt   (fcnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready: forced stall window, else random or always-ready.
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_n > 0) begin
            tready = 1'b0;
            stall_n--;
        end else begin
            tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Beat monitor: records accepted beats and any change of a stalled beat.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            if (prev_stall && (tvalid !== 1'b1 || {tdata, tuser, tlast} !== prev_beat)) stall_viol++;
            prev_stall = tvalid && !tready;
            prev_beat  = {tdata, tuser, tlast};
            if (tvalid === 1'b1 && tready === 1'b1) begin
                beats.push_back({tdata, tuser, tlast});
                bcyc.push_back(cyc);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lfsr_at(int n);
        logic [15:0] s = 16'hACE1;
        for (int k = 0; k < n; k++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        return s;
    endfunction

    // Reference pixel for beat n of a frame, straight from the pattern definitions.
    function automatic pix_t exp_beat(int m, logic [7:0] cv, int n);
        pix_t p;
        int x = n % W;
        int y = n / W;
        int v;
        p.u = (n == 0);
        p.l = (x == W - 1);
        p.d = '0;
        for (int c = 0; c < 3; c++) begin
            case (m)
                0: v = (x + c) % 256;
                1: v = (y + c) % 256;
                2: v = (((x >> CL) ^ (y >> CL)) & 1) ? 255 : 0;
                3: v = int'(cv);
                4: v = int'(lfsr_at(n)) % 256;
                default: v = 0;
            endcase
            p.d[c*8 +: 8] = 8'(v);
        end
        return p;
    endfunction

    task automatic pulse_start();
        @(posedge clk);
        #1;
        i_start   = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int g = 0;
        while (busy !== 1'b0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic wait_beats(input int n, output bit ok);
        int g = 0;
        while (beats.size() < n && g < 3000) begin
            @(negedge clk);
            g++;
        end
        ok = (beats.size() >= n);
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({tvalid, tuser, tlast, busy} !== 4'b0)
            $display("FAIL reset_ctrl got %b want 0000", {tvalid, tuser, tlast, busy});
        else passed++;
        total++;
        if (tdata !== 24'h0) $display("FAIL reset_tdata got %h want 000000", tdata);
        else passed++;
        total++;
        if (fcnt !== 16'd0) $display("FAIL reset_fcnt got %0d want 0", fcnt);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ok = (busy === 1'b0 && tvalid === 1'b0);
        total++;
        if (ok !== 1'b1) $display("FAIL reset_idle busy=%b tvalid=%b want 0 0", busy, tvalid);
        else passed++;
    endtask

    task automatic test_hramp();
        bit ok;
        pix_t e;
        rand_rdy = 1'b0;
        i_mode   = 3'd0;
        beats.delete();
        bcyc.delete();
        pulse_start();
        wait_idle(ok);
        exp_frames++;
        total++;
        if (ok !== 1'b1) $display("FAIL hramp_timeout busy=%b want 0", busy);
        else passed++;
        total++;
        if (beats.size() !== NB) $display("FAIL hramp_count got %0d want %0d", beats.size(), NB);
        else passed++;
        for (int i = 0; i < beats.size(); i++) begin
            e = exp_beat(0, 8'h00, i);
            total++;
            if (beats[i] !== e) $display("FAIL hramp_beat%0d got %h want %h", i, beats[i], e);
            else passed++;
        end
        if (beats.size() == NB) begin
            total++;
            if (bcyc[0] !== start_cyc + 1)
                $display("FAIL hramp_latency got %0d want %0d", bcyc[0] - start_cyc, 1);
            else passed++;
            for (int i = 1; i < NB; i++) begin
                total++;
                if (bcyc[i] - bcyc[i-1] !== ((i % W == 0) ? HB + 1 : 1))
                    $display("FAIL hramp_gap%0d got %0d want %0d", i, bcyc[i] - bcyc[i-1],
                             (i % W == 0) ? HB + 1 : 1);
                else passed++;
            end
            total++;
            if (beats[5].d[23:16] !== 8'd7) $display("FAIL hramp_ch2_beat5 got %0d want 7", beats[5].d[23:16]);
            else passed++;
        end
        total++;
        if (fcnt !== 16'(exp_frames)) $display("FAIL hramp_fcnt got %0d want %0d", fcnt, exp_frames);
        else passed++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int m;
        logic [7:0] cv;
        pix_t e;
        for (int f = 0; f < 4; f++) begin
            m  = (f == 0) ? 0 : int'($urandom_range(0, 7));
            cv = 8'($urandom);
            i_mode        = 3'(m);
            i_const_value = cv;
            beats.delete();
            bcyc.delete();
            stall_viol = 0;
            rand_rdy   = 1'b1;
            pulse_start();
            wait_idle(ok);
            rand_rdy = 1'b0;
            exp_frames++;
            total++;
            if (ok !== 1'b1 || beats.size() !== NB)
                $display("FAIL bp_count mode %0d got %0d beats want %0d", m, beats.size(), NB);
            else passed++;
            for (int i = 0; i < beats.size(); i++) begin
                e = exp_beat(m, cv, i);
                total++;
                if (beats[i] !== e) $display("FAIL bp_beat%0d mode %0d got %h want %h", i, m, beats[i], e);
                else passed++;
            end
            total++;
            if (stall_viol !== 0) $display("FAIL bp_stall_hold got %0d changes want 0", stall_viol);
            else passed++;
            total++;
            if (fcnt !== 16'(exp_frames)) $display("FAIL bp_fcnt got %0d want %0d", fcnt, exp_frames);
            else passed++;
        end
    endtask

    task automatic test_continuous();
        bit ok1, ok2, ok3;
        pix_t e;
        beats.delete();
        bcyc.delete();
        rand_rdy      = 1'b0;
        i_const_value = 8'h5A;
        @(posedge clk);
        #1;
        i_mode       = 3'd0;
        i_continuous = 1'b1;
        i_enable     = 1'b1;
        wait_beats(40, ok1);
        i_mode = 3'd3;
        wait_beats(70, ok2);
        i_enable = 1'b0;
        wait_idle(ok3);
        i_continuous = 1'b0;
        exp_frames += 3;
        total++;
        if ({ok1, ok2, ok3} !== 3'b111 || beats.size() !== 3 * NB)
            $display("FAIL cont_count got %0d beats want %0d", beats.size(), 3 * NB);
        else passed++;
        for (int i = 0; i < beats.size(); i++) begin
            e = exp_beat((i < 2 * NB) ? 0 : 3, 8'h5A, i % NB);
            total++;
            if (beats[i] !== e) $display("FAIL cont_beat%0d got %h want %h", i, beats[i], e);
            else passed++;
        end
        if (beats.size() == 3 * NB) begin
            for (int f = 1; f < 3; f++) begin
                total++;
                if (bcyc[f*NB] - bcyc[f*NB-1] !== VB + 1)
                    $display("FAIL cont_vgap%0d got %0d want %0d", f, bcyc[f*NB] - bcyc[f*NB-1], VB + 1);
                else passed++;
            end
        end
        total++;
        if (fcnt !== 16'(exp_frames) || busy !== 1'b0)
            $display("FAIL cont_end fcnt %0d busy %b want %0d 0", fcnt, busy, exp_frames);
        else passed++;
    endtask

    task automatic test_noise();
        bit ok1, ok2, ok3;
        pix_t qa[$];
        pix_t e;
        i_mode   = 3'd4;
        rand_rdy = 1'b0;
        beats.delete();
        pulse_start();
        wait_idle(ok1);
        qa = beats;
        beats.delete();
        stall_viol = 0;
        pulse_start();
        wait_beats(12, ok2);
        stall_n = 8;
        wait_idle(ok3);
        exp_frames += 2;
        total++;
        if ({ok1, ok2, ok3} !== 3'b111 || qa.size() !== NB || beats.size() !== NB)
            $display("FAIL noise_count got %0d and %0d want %0d", qa.size(), beats.size(), NB);
        else passed++;
        if (qa.size() == NB && beats.size() == NB) begin
            total++;
            if (qa[0].d[7:0] !== 8'hE1) $display("FAIL noise_first got %h want e1", qa[0].d[7:0]);
            else passed++;
            for (int i = 0; i < NB; i++) begin
                e = exp_beat(4, 8'h00, i);
                total++;
                if (qa[i] !== e || beats[i] !== e)
                    $display("FAIL noise_beat%0d got %h / %h want %h", i, qa[i], beats[i], e);
                else passed++;
            end
        end
        total++;
        if (stall_viol !== 0) $display("FAIL noise_stall_hold got %0d changes want 0", stall_viol);
        else passed++;
        total++;
        if (fcnt !== 16'(exp_frames)) $display("FAIL noise_fcnt got %0d want %0d", fcnt, exp_frames);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        bit ok1, ok2;
        pix_t e;
        i_mode   = 3'd0;
        rand_rdy = 1'b0;
        beats.delete();
        pulse_start();
        wait_beats(10, ok1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_frames = 0;
        total++;
        if (ok1 !== 1'b1 || {tvalid, tuser, tlast, busy} !== 4'b0 || tdata !== 24'h0 || fcnt !== 16'd0)
            $display("FAIL rst_mid_outputs got v%b u%b l%b b%b d%h f%0d want all 0",
                     tvalid, tuser, tlast, busy, tdata, fcnt);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        beats.delete();
        pulse_start();
        wait_idle(ok2);
        exp_frames++;
        e = exp_beat(0, 8'h00, 0);
        total++;
        if (ok2 !== 1'b1 || beats.size() !== NB)
            $display("FAIL rst_mid_count got %0d want %0d", beats.size(), NB);
        else passed++;
        if (beats.size() > 0) begin
            total++;
            if (beats[0] !== e) $display("FAIL rst_mid_first got %h want %h", beats[0], e);
            else passed++;
        end
        total++;
        if (fcnt !== 16'(exp_frames)) $display("FAIL rst_mid_fcnt got %0d want %0d", fcnt, exp_frames);
        else passed++;
    endtask

    task automatic test_start_while_busy();
        bit ok1, ok2, ok3;
        i_mode   = 3'd1;
        rand_rdy = 1'b0;
        beats.delete();
        pulse_start();
        wait_beats(5, ok1);
        pulse_start();
        wait_beats(NB, ok2);
        @(posedge clk);
        #1;
        i_start = 1'b1;
        total++;
        if (busy !== 1'b1) $display("FAIL busy_in_vblank got %b want 1", busy);
        else passed++;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_idle(ok3);
        repeat (10) @(posedge clk);
        #1;
        exp_frames++;
        total++;
        if ({ok1, ok2, ok3} !== 3'b111 || beats.size() !== NB || busy !== 1'b0)
            $display("FAIL busy_start_count got %0d beats busy %b want %0d 0", beats.size(), busy, NB);
        else passed++;
        total++;
        if (fcnt !== 16'(exp_frames)) $display("FAIL busy_start_fcnt got %0d want %0d", fcnt, exp_frames);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_hramp();
        test_backpressure();
        test_continuous();
        test_noise();
        test_reset_midframe();
        test_start_while_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
